// File: rtl/shift_sequencer.sv
// shift_sequencer: queues LOAD/RSH/LSH/READ commands and sequences a 4-bit
// shift register one step per cycle, returning its OUT/FLAG with a DONE pulse.
module shift_sequencer #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [3:0]       CMD_DATA,
  input  logic [CNT_W-1:0] CMD_COUNT,
  output logic [3:0]       SR_DATA,
  output logic             SR_LOAD,
  output logic [1:0]       SR_SHIFT,
  input  logic [3:0]       SR_OUT,
  input  logic             SR_FLAG,
  output logic             DONE,
  output logic [3:0]       RESULT,
  output logic             RESULT_FLAG
);
  localparam int PW = $clog2(DEPTH);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_RSH  = 2'b01;
  localparam logic [1:0] OP_LSH  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  typedef struct packed {
    logic [1:0]       op;
    logic [3:0]       data;
    logic [CNT_W-1:0] count;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_SETTLE, S_DONE
  } state_t;

  cmd_t             mem [DEPTH];
  logic [PW:0]      wr_ptr, rd_ptr;
  logic             full, empty, push, pop;
  cmd_t             head;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       dir, dir_nxt;
  logic             shift_d;   // shifter was stepped on the previous cycle
  logic             sticky;

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign CMD_READY = !full;
  assign push      = CMD_VALID && !full;
  assign pop       = (state == S_IDLE) && !empty;
  assign head      = mem[rd_ptr[PW-1:0]];

  // Command storage; contents need no reset, pointers define validity.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[PW-1:0]] <= {CMD_OP, CMD_DATA, CMD_COUNT};
  end

  // FIFO pointers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Direction of the command being started, held for its whole run.
  always_comb begin
    dir_nxt = dir;
    if (pop) dir_nxt = (head.op == OP_LSH) ? 2'b10 : 2'b01;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          case (head.op)
            OP_LOAD: state_nxt = S_LOAD;
            OP_RSH,
            OP_LSH:  state_nxt = (head.count != '0) ? S_SHIFT : S_SETTLE;
            OP_READ: state_nxt = S_SETTLE;
            default: state_nxt = S_SETTLE;
          endcase
        end
      end
      S_LOAD:   state_nxt = S_SETTLE;
      S_SHIFT:  if (cnt == CNT_W'(1)) state_nxt = S_SETTLE;
      S_SETTLE: state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register and shifter-side outputs, registered from the next state.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= S_IDLE;
      dir      <= 2'b00;
      SR_LOAD  <= 1'b0;
      SR_SHIFT <= 2'b00;
      DONE     <= 1'b0;
    end else begin
      state    <= state_nxt;
      dir      <= dir_nxt;
      SR_LOAD  <= (state_nxt == S_LOAD);
      SR_SHIFT <= (state_nxt == S_SHIFT) ? dir_nxt : 2'b00;
      DONE     <= (state_nxt == S_DONE);
    end
  end

  // Step counter, load data, flag accumulation and result capture.
  // FLAG is sampled one cycle after a step, once the shifter has updated.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt         <= '0;
      SR_DATA     <= 4'h0;
      shift_d     <= 1'b0;
      sticky      <= 1'b0;
      RESULT      <= 4'h0;
      RESULT_FLAG <= 1'b0;
    end else begin
      shift_d <= (SR_SHIFT != 2'b00);
      if (pop) begin
        cnt    <= head.count;
        sticky <= 1'b0;
        if (head.op == OP_LOAD) SR_DATA <= head.data;
      end else begin
        if (state == S_SHIFT) cnt <= cnt - 1'b1;
        if (shift_d) sticky <= sticky | SR_FLAG;
      end
      if (state == S_SETTLE) begin
        RESULT      <= SR_OUT;
        RESULT_FLAG <= sticky | (shift_d & SR_FLAG);
      end
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer: attached 4-bit shifter, directed scenarios
// plus random command streams scored against an arithmetic reference model.
module tb_shift_sequencer;
  localparam int DEPTH = 2;
  localparam int CNT_W = 3;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [1:0]       CMD_OP;
  logic [3:0]       CMD_DATA;
  logic [CNT_W-1:0] CMD_COUNT;
  logic [3:0]       SR_DATA;
  logic             SR_LOAD;
  logic [1:0]       SR_SHIFT;
  logic [3:0]       SR_OUT;
  logic             SR_FLAG;
  logic             DONE;
  logic [3:0]       RESULT;
  logic             RESULT_FLAG;

  shift_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
    .CMD_DATA(CMD_DATA), .CMD_COUNT(CMD_COUNT),
    .SR_DATA(SR_DATA), .SR_LOAD(SR_LOAD), .SR_SHIFT(SR_SHIFT),
    .SR_OUT(SR_OUT), .SR_FLAG(SR_FLAG),
    .DONE(DONE), .RESULT(RESULT), .RESULT_FLAG(RESULT_FLAG)
  );

  always #5 CLK = ~CLK;

  // Attached ShiftRegister: FLAG is the bit shifted out on the last step.
  logic [3:0] sh   = 4'h0;
  logic       shf  = 1'b0;
  always @(posedge CLK) begin
    if (SR_LOAD) begin
      sh <= SR_DATA; shf <= 1'b0;
    end else if (SR_SHIFT == 2'b10) begin
      {shf, sh} <= {sh, 1'b0};
    end else if (SR_SHIFT == 2'b01) begin
      {sh, shf} <= {1'b0, sh};
    end
  end
  assign SR_OUT  = sh;
  assign SR_FLAG = shf;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: expected outcome of each accepted command, in order.
  typedef struct {
    int         d;       // cycle index at which DONE is expected high
    logic [1:0] op;
    logic [3:0] data;
    int         n;       // expected number of SR_SHIFT-active cycles
    logic [3:0] res;
    logic       flg;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] mreg   = 4'h0;
  int         last_d = -10;

  function automatic void model_accept(input int op, input int d, input int n, input int e0);
    exp_t        e;
    int          lat;
    int          p;
    logic [15:0] w;
    e.op = 2'(op); e.data = 4'(d); e.n = 0; e.flg = 1'b0;
    lat = 2;
    if (op == 0) begin
      mreg = 4'(d); lat = 3;
    end else if ((op == 1 || op == 2) && n > 0) begin
      lat = n + 2; e.n = n;
      if (op == 2) begin
        w = {12'h000, mreg} << n;
        e.flg = |w[15:4]; mreg = w[3:0];
      end else begin
        w = {mreg, 12'h000} >> n;
        e.flg = |w[11:0]; mreg = w[15:12];
      end
    end
    e.res = mreg;
    p = (e0 + 1 > last_d + 2) ? e0 + 1 : last_d + 2;
    e.d = p + lat - 1;
    last_d = e.d;
    sb.push_back(e);
  endfunction

  // Monitor: per-cycle shifter drive checks and per-DONE result scoring.
  int sh_cnt = 0;
  int ld_cnt = 0;
  always @(negedge CLK) begin
    if (!RESET) begin
      sh_cnt = 0; ld_cnt = 0;
    end else begin
      if (SR_LOAD || SR_SHIFT != 2'b00) begin
        chk("load_shift_exclusive", int'(SR_LOAD && SR_SHIFT != 2'b00), 0);
        if (sb.size() > 0) begin
          if (SR_LOAD) chk("sr_data", int'(SR_DATA), int'(sb[0].data));
          if (SR_SHIFT != 2'b00)
            chk("shift_dir", int'(SR_SHIFT), (sb[0].op == 2'b10) ? 2 : 1);
        end
      end
      if (SR_LOAD) ld_cnt++;
      if (SR_SHIFT != 2'b00) sh_cnt++;
      if (DONE) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cycle", cyc, e.d);
          chk("result", int'(RESULT), int'(e.res));
          chk("result_flag", int'(RESULT_FLAG), int'(e.flg));
          chk("shift_cycles", sh_cnt, e.n);
          chk("load_cycles", ld_cnt, (e.op == 2'b00) ? 1 : 0);
        end
        sh_cnt = 0; ld_cnt = 0;
      end
    end
  end

  // Present one command at a negedge; returns at the negedge after acceptance.
  task automatic send(input int op, input int d, input int n);
    int guard = 0;
    CMD_VALID = 1'b1; CMD_OP = 2'(op); CMD_DATA = 4'(d); CMD_COUNT = CNT_W'(n);
    while (!CMD_READY && guard < 200) begin
      @(negedge CLK); guard++;
    end
    if (guard >= 200) begin
      chk("accept_timeout", guard, 0);
    end else begin
      model_accept(op, d, n, cyc + 1);
    end
    @(negedge CLK);
    CMD_VALID = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 300) begin
      @(negedge CLK); guard++;
    end
    chk("drain", sb.size(), 0);
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    RESET = 1'b0; CMD_VALID = 1'b1; CMD_OP = 2'b00; CMD_DATA = 4'hF; CMD_COUNT = '0;

    // Reset with a command presented: everything stays quiet.
    repeat (4) begin
      @(negedge CLK);
      chk("reset_outputs", int'({SR_LOAD, SR_SHIFT, DONE, RESULT, RESULT_FLAG, SR_DATA}), 0);
    end
    RESET = 1'b1; CMD_VALID = 1'b0;
    repeat (6) @(negedge CLK);
    chk("ready_after_reset", int'(CMD_READY), 1);
    chk("result_after_reset", int'(RESULT), 0);

    // LOAD 1011.
    send(0, 4'b1011, 0);
    drain();
    chk("t2_result", int'(RESULT), 4'b1011);
    chk("t2_flag", int'(RESULT_FLAG), 0);

    // LOAD 0110, LSH 2.
    send(0, 4'b0110, 0);
    send(2, 0, 2);
    drain();
    chk("t3_result", int'(RESULT), 4'b1000);
    chk("t3_flag", int'(RESULT_FLAG), 1);

    // LOAD 1000, RSH 3, then LSH 0.
    send(0, 4'b1000, 0);
    send(1, 0, 3);
    drain();
    chk("t4_result", int'(RESULT), 4'b0001);
    chk("t4_flag", int'(RESULT_FLAG), 0);
    send(2, 0, 0);
    drain();
    chk("t4_zero_result", int'(RESULT), 4'b0001);

    // Back-pressure behind a long shift.
    send(2, 0, 7);
    send(0, 4'b0101, 0);
    send(2, 0, 1);
    chk("t5_ready_full", int'(CMD_READY), 0);
    send(3, 0, 0);
    drain();
    chk("t5_last_result", int'(RESULT), 4'b1010);

    // Random command stream, including back-to-back and gapped traffic.
    for (int i = 0; i < 80; i++) begin
      send(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
    drain();

    // Reset in the middle of a shift with another command queued.
    send(0, 4'b1111, 0);
    send(2, 0, 7);
    send(3, 0, 0);
    begin
      int guard = 0;
      while (SR_SHIFT == 2'b00 && guard < 50) begin
        @(negedge CLK); guard++;
      end
      chk("t6_shift_seen", int'(SR_SHIFT), 2);
    end
    @(negedge CLK);
    #2 RESET = 1'b0;
    sb.delete(); last_d = -10;
    #1;
    chk("t6_async_shift", int'(SR_SHIFT), 0);
    chk("t6_async_done", int'(DONE), 0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    repeat (12) @(negedge CLK);
    chk("t6_result", int'(RESULT), 0);
    chk("t6_flag", int'(RESULT_FLAG), 0);
    chk("t6_ready", int'(CMD_READY), 1);

    // Still functional afterwards, with nothing left over in the queue.
    send(0, 4'b1100, 0);
    send(3, 0, 0);
    drain();
    chk("t6_post_result", int'(RESULT), 4'b1100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Command-driven controller directly upstream of the 4-bit ShiftRegister in the ALU.
- Queues load/shift commands in a small FIFO and drives the shifter's load-enable, shift-select and data inputs cycle by cycle; multi-bit shifts run as N single-bit steps.
- Collects the shifter's OUT and FLAG and returns a result with a one-cycle DONE pulse.

Parameters:
- DEPTH, 2, command FIFO entries; power of two, >=2.
- CNT_W, 3, width of shift count; max shift = 2^CNT_W-1.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-low reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  FIFO can accept; equals !full, from registered state.
- CMD_OP  in  2  00 LOAD, 01 RSH, 10 LSH, 11 READ.
- CMD_DATA  in  4  load value; ignored unless LOAD.
- CMD_COUNT  in  CNT_W  shift steps; ignored unless RSH/LSH.
- SR_DATA  out  4  to shifter IN.
- SR_LOAD  out  1  to shifter LOAD_ENABLE.
- SR_SHIFT  out  2  to shifter {LSH,RSH}: 10 left, 01 right, 00 hold.
- SR_OUT  in  4  shifter OUT.
- SR_FLAG  in  1  shifter FLAG.
- DONE  out  1  one-cycle completion pulse.
- RESULT  out  4  SR_OUT captured at completion; held until next completion.
- RESULT_FLAG  out  1  sticky FLAG for the completed command; held likewise.

Behaviour:
- Reset (RESET low, async):
  - FIFO emptied; FSM forced to IDLE; counter and sticky flag cleared.
  - SR_LOAD=0, SR_SHIFT=00, SR_DATA=0, DONE=0, RESULT=0, RESULT_FLAG=0.
  - CMD_READY=1 once reset is released.
  - A reset mid-command aborts it: no DONE, and queued commands are lost.
- FIFO:
  - Push on the posedge where CMD_VALID && CMD_READY.
  - Strict FIFO order; wrap-around pointers.
  - Push while full is impossible (READY=0), even if a pop occurs that cycle; there is no bypass.
- FSM states: IDLE, LOAD, SHIFT, SETTLE, DONE. All SR_* and DONE outputs are registered and decoded from the state.
  - IDLE: if FIFO non-empty, pop at the posedge, clear sticky flag and branch by op:
    - LOAD -> LOAD; latch SR_DATA=CMD_DATA.
    - LSH/RSH with COUNT>0 -> SHIFT; counter=COUNT.
    - LSH/RSH with COUNT=0, or READ -> SETTLE.
  - LOAD: SR_LOAD=1 for exactly one cycle, then SETTLE.
  - SHIFT: SR_SHIFT=10 (LSH) or 01 (RSH) each cycle. Counter decrements every posedge; leave to SETTLE when counter reaches 1. SR_SHIFT is active for exactly COUNT cycles.
  - SETTLE: one cycle so the last shifter update is visible. At its closing posedge, RESULT<=SR_OUT and RESULT_FLAG<=sticky; go to DONE.
  - DONE: DONE=1 for one cycle, then IDLE. Back-to-back commands are therefore separated by one IDLE cycle.
- Sticky flag: OR of SR_FLAG sampled at every posedge whose preceding cycle had SR_SHIFT!=00, including the posedge closing SETTLE. LOAD and READ give RESULT_FLAG=0.
- Latency, counted from the acceptance posedge E0 to the first cycle DONE is high:
  - LOAD: 3 cycles.
  - Shift of N>0 steps: N+2 cycles.
  - COUNT=0 or READ: 2 cycles.
  - Add queueing delay when commands are already pending.
- SR_LOAD and SR_SHIFT are never active in the same cycle. SR_DATA holds its last loaded value between commands.

Test Plan:
1. Reset: hold RESET low with CMD_VALID=1 -> CMD_READY=1 after release; no push accepted during reset; all outputs 0.
2. LOAD 1011, with a ShiftRegister attached -> SR_LOAD high one cycle with SR_DATA=1011; DONE at E0+3; RESULT=1011, RESULT_FLAG=0.
3. After loading 0110, LSH COUNT=2 -> SR_SHIFT=10 for exactly 2 cycles; DONE at E0+4; RESULT=1000, RESULT_FLAG=1 (second step shifts out a 1).
4. After loading 1000, RSH COUNT=3 -> SR_SHIFT=01 for 3 cycles; RESULT=0001, RESULT_FLAG=0. Then LSH COUNT=0 -> no SR_SHIFT activity; DONE at E0+2; RESULT=0001.
5. Back-pressure: while LSH COUNT=7 runs, present 3 commands back-to-back -> CMD_READY drops after 2 are queued; third accepted after the next pop; DONE pulses and results appear in push order.
6. Reset mid-shift: assert RESET during an LSH COUNT=7 -> SR_SHIFT goes to 00 immediately (asynchronously); no DONE; FIFO empty; RESULT retains 0.
